// File: rtl/addsub_result_stage.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | addsub_result_stage: 2-entry result FIFO for an add/sub unit, with       |
// | optional {N,Z,C,V} flags and a saturating overflow counter               |
// | (macro ADDSUB_RESULT_FLAGS_EN).                                          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module addsub_result_stage #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_is_sub,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  output logic [CNT_W-1:0] ovf_count
);

  logic [1:0]       count_q, count_d;
  logic [WIDTH-1:0] res0_q, res0_d;
  logic [WIDTH-1:0] res1_q, res1_d;
  logic             push, pop;
  logic             head_from_in, head_from_tail, tail_from_in;

  // Gating with RESETN keeps in_ready low for as long as reset is held.
  assign in_ready   = RESETN && (count_q != 2'd2);
  assign out_valid  = (count_q != 2'd0);
  assign push       = in_valid && in_ready;
  assign pop        = out_valid && out_ready;
  assign out_result = res0_q;

  always_comb begin
    head_from_in   = push && ((count_q == 2'd0) || ((count_q == 2'd1) && pop));
    head_from_tail = pop && (count_q == 2'd2);
    tail_from_in   = push && (count_q == 2'd1) && !pop;
    count_d        = count_q + {1'b0, push} - {1'b0, pop};
    res0_d         = res0_q;
    res1_d         = res1_q;
    if (head_from_in)        res0_d = in_result;
    else if (head_from_tail) res0_d = res1_q;
    if (tail_from_in)        res1_d = in_result;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      count_q <= 2'd0;
      res0_q  <= '0;
      res1_q  <= '0;
    end else begin
      count_q <= count_d;
      res0_q  <= res0_d;
      res1_q  <= res1_d;
    end
  end

`ifdef ADDSUB_RESULT_FLAGS_EN
  logic [WIDTH-1:0] sum_lo;
  logic [3:0]       new_flags;
  logic [3:0]       flags0_q, flags0_d;
  logic [3:0]       flags1_q, flags1_d;
  logic [CNT_W-1:0] ovf_q, ovf_d;
  logic             sa, sb, sr;

  assign sum_lo = in_a + in_b;
  assign sa     = in_a[WIDTH-1];
  assign sb     = in_b[WIDTH-1];
  assign sr     = in_result[WIDTH-1];

  always_comb begin
    new_flags[3] = sr;
    new_flags[2] = (in_result == '0);
    if (in_is_sub) begin
      new_flags[1] = (in_a >= in_b);
      new_flags[0] = (sa != sb) && (sr != sa);
    end else begin
      // The wrapped sum is below an operand exactly when bit WIDTH carried out.
      new_flags[1] = (sum_lo < in_a);
      new_flags[0] = (sa == sb) && (sr != sa);
    end
  end

  always_comb begin
    flags0_d = flags0_q;
    flags1_d = flags1_q;
    ovf_d    = ovf_q;
    if (head_from_in)        flags0_d = new_flags;
    else if (head_from_tail) flags0_d = flags1_q;
    if (tail_from_in)        flags1_d = new_flags;
    if (push && new_flags[0] && (ovf_q != {CNT_W{1'b1}}))
      ovf_d = ovf_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      flags0_q <= 4'd0;
      flags1_q <= 4'd0;
      ovf_q    <= '0;
    end else begin
      flags0_q <= flags0_d;
      flags1_q <= flags1_d;
      ovf_q    <= ovf_d;
    end
  end

  assign out_flags = flags0_q;
  assign ovf_count = ovf_q;
`else
  logic unused_ops;
  assign unused_ops = ^{in_is_sub, in_a, in_b};
  assign out_flags  = 4'd0;
  assign ovf_count  = '0;
`endif

endmodule
`default_nettype wire

// File: doc/addsub_result_stage.md
ADDSUB_RESULT_STAGE -- requirements
Module: addsub_result_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 32: operand/result width in bits.
REQ-002 SHALL have parameter CNT_W, default 8: width of the overflow event counter.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  sole clock, rising edge.
REQ-005 RESETN  in  1  asynchronous active-low reset.
REQ-006 in_valid  in  1  upstream holds a valid add/sub operation.
REQ-007 in_ready  out  1  stage can accept this cycle.
REQ-008 in_is_sub  in  1  1 = a-b, 0 = a+b; same value driven to the adder/subtractor.
REQ-009 in_a, in_b  in  WIDTH  operands given to the adder/subtractor.
REQ-010 in_result  in  WIDTH  adder/subtractor output for in_a, in_b, in_is_sub.
REQ-011 out_valid  out  1  head entry valid.
REQ-012 out_ready  in  1  downstream accepts the head entry.
REQ-013 out_result  out  WIDTH  captured result.
REQ-014 out_flags  out  4  {N,Z,C,V} for the head entry.
REQ-015 ovf_count  out  CNT_W  saturating count of accepted entries with V=1.

Function
REQ-016 SHALL accept on the rising CLK edge when in_valid & in_ready; SHALL pop on the rising CLK edge when out_valid & out_ready.
REQ-017 SHALL buffer up to 2 entries in order (FIFO); in_ready = (occupancy < 2), registered-free combinational from occupancy.
REQ-018 Latency: an entry accepted at edge k into an empty buffer SHALL appear on out_* with out_valid=1 after edge k (next cycle).
REQ-019 Occupancy 1 with push and pop on the same edge SHALL keep occupancy 1, with the new entry at the head.
REQ-020 Occupancy 2: in_ready=0 and no push; a pop on that edge SHALL raise in_ready the following cycle.
REQ-021 Occupancy 0: out_valid=0; out_result/out_flags hold their last values (don't-care to downstream).
REQ-022 out_* SHALL be stable while out_valid=1 and out_ready=0.
REQ-023 Flags SHALL be computed at acceptance from in_a, in_b, in_is_sub, in_result; in_result SHALL pass through unmodified.
REQ-024 Z = (in_result == 0); N = in_result[WIDTH-1].
REQ-025 C add = carry out of unsigned in_a+in_b (bit WIDTH of a WIDTH+1 sum); C sub = 1 when in_a >= in_b unsigned (no borrow).
REQ-026 V add = in_a, in_b same sign and in_result sign differs; V sub = in_a, in_b signs differ and in_result sign differs from in_a.
REQ-027 ovf_count SHALL increment by 1 on each accepted entry with V=1 and saturate at 2^CNT_W-1.

Reset
REQ-028 While RESETN=0: occupancy 0, out_valid=0, in_ready=0, out_result=0, out_flags=0, ovf_count=0, asynchronously.
REQ-029 First cycle after RESETN rises: in_ready=1; a reset mid-transfer SHALL discard all buffered entries, with no partial pop or push.

Configuration
REQ-030 Macro ADDSUB_RESULT_FLAGS_EN defined: flags and ovf_count SHALL behave per REQ-024 to REQ-027.
REQ-031 Macro ADDSUB_RESULT_FLAGS_EN undefined: out_flags and ovf_count SHALL be constant 0, with no flag storage; the handshake and result path SHALL be unchanged.

Verification
REQ-032 Add: a=312, b=1000, is_sub=0, result=1312, out_ready=1 -> out_result=1312, flags N0 Z0 C0 V0, one cycle later.
REQ-033 Sub: a=312, b=1000, is_sub=1, result=-688 (0xFFFFFD50) -> N1 Z0 C0 V0; a=b=5, sub, result=0 -> N0 Z1 C1 V0.
REQ-034 Overflow: a=0x7FFFFFFF, b=1, add, result=0x80000000 -> N1 V1 C0, ovf_count=1; a=0xFFFFFFFF, b=1, add, result=0 -> Z1 C1 V0.
REQ-035 Backpressure: out_ready=0, offer 3 entries back-to-back -> 2 accepted, in_ready=0, third held; out_ready=1 -> drained in order, no loss or duplicate.
REQ-036 Reset mid-operation with 2 entries buffered -> out_valid=0 immediately, ovf_count=0, in_ready=1 first cycle after release; 300 accepted V=1 entries -> ovf_count=255.
REQ-037 Build without ADDSUB_RESULT_FLAGS_EN, repeat REQ-034 -> out_flags=0, ovf_count=0, results identical.
